uart_autobaud: RTL and testbench

UART_AUTOBAUD -- requirements
Module: uart_autobaud

---
 rtl/uart_autobaud_pkg.sv | 44 ++++
 rtl/uart_line_sync.sv | 26 ++
 rtl/uart_autobaud.sv | 134 +++++++++++++
 tb/tb_uart_autobaud.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/uart_autobaud_pkg.sv
// Shared UART definitions: autobaud FSM encoding, reset defaults and the sync character.
package uart_autobaud_pkg;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_WAIT_HIGH  = 3'd1,
    ST_WAIT_START = 3'd2,
    ST_MEASURE    = 3'd3,
    ST_VERIFY     = 3'd4
  } state_t;

  typedef struct packed {
    state_t     state;
    logic [2:0] edge_cnt;
    logic       line_level;
    logic       line_rise;
    logic       line_fall;
  } dbg_t;

  localparam logic [7:0] UART_DEFAULT_DIVIDER = 8'd217;
  localparam int         UART_MIN_DIVIDER     = 4;
  localparam logic [7:0] UART_SYNC_CHAR       = 8'h55;
  localparam int         HIGH_SAMPLES         = 16;
  localparam int         CNT_W                = 11;
  localparam logic [CNT_W-1:0] CNT_MAX        = '1;

  // Falling edges inside the data bits of a character (start-bit edge excluded).
  function automatic int count_falls(input logic [7:0] c);
    int n;
    n = 0;
    for (int i = 1; i < 8; i++) begin
      if (c[i-1] && !c[i]) n++;
    end
    return n;
  endfunction

  localparam int SYNC_FALLS = count_falls(UART_SYNC_CHAR);

  // The measured span covers 8 bit times; divide by 8 with round-to-nearest.
  function automatic logic [11:0] round_div(input logic [11:0] span);
    return (span + 12'd4) >> 3;
  endfunction

endpackage

// File: rtl/uart_line_sync.sv
// Two-flop synchronizer for an asynchronous serial line plus edge detection on the synced level.
module uart_line_sync (
  input  logic clock_i,
  input  logic reset_i,
  input  logic serial_i,
  output logic level,
  output logic rise,
  output logic fall
);

  // [0],[1] form the synchronizer; [2] is the previous synchronized level.
  logic [2:0] sync_q;

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      sync_q <= 3'b111;
    end else begin
      sync_q <= {sync_q[1:0], serial_i};
    end
  end

  assign level = sync_q[1];
  assign rise  = sync_q[1] & ~sync_q[2];
  assign fall  = ~sync_q[1] & sync_q[2];

endmodule

// File: rtl/uart_autobaud.sv
// Measures the bit period of a received 0x55 sync character and publishes it as a clock divider.
// Handshake: start_i is a one-cycle request honoured only while idle; done_o/error_o are one-cycle results.
module uart_autobaud
  import uart_autobaud_pkg::*;
#(
  parameter logic [7:0] DEFAULT_DIVIDER = UART_DEFAULT_DIVIDER,
  parameter int         MIN_DIVIDER     = UART_MIN_DIVIDER
) (
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic       start_i,
  input  logic       serial_i,
  output logic [7:0] clock_divider_o,
  output logic       locked_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       error_o,
  output dbg_t       debug_o
);

  localparam logic [11:0] MIN_DIV12 = 12'(MIN_DIVIDER);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       edge_q;
  logic [4:0]       high_q;
  logic [7:0]       div_q;
  logic             line_level, line_rise, line_fall;
  logic             succeed, fail;

  logic [11:0] cnt_inc, meas_div, verify_len;
  logic        div_ok, last_fall, verify_at, high_done;

  uart_line_sync u_line_sync (
    .clock_i  (clock_i),
    .reset_i  (reset_i),
    .serial_i (serial_i),
    .level    (line_level),
    .rise     (line_rise),
    .fall     (line_fall)
  );

  // cnt_inc is the span including the current cycle, so it equals the start-edge-to-edge distance.
  assign cnt_inc    = {1'b0, cnt_q} + 12'd1;
  assign meas_div   = round_div(cnt_inc);
  assign div_ok     = (meas_div >= MIN_DIV12) && (meas_div <= 12'd255);
  assign last_fall  = line_fall && (edge_q == 3'(SYNC_FALLS - 1));
  assign verify_len = {4'b0, div_q} + {5'b0, div_q[7:1]};
  assign verify_at  = (cnt_inc == verify_len);
  assign high_done  = line_level && (high_q == 5'(HIGH_SAMPLES - 1));

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:       if (start_i) state_d = ST_WAIT_HIGH;
      ST_WAIT_HIGH:  if (high_done) state_d = ST_WAIT_START;
      ST_WAIT_START: if (line_fall) state_d = ST_MEASURE;
      ST_MEASURE: begin
        if (last_fall)             state_d = div_ok ? ST_VERIFY : ST_IDLE;
        else if (cnt_q == CNT_MAX) state_d = ST_IDLE;
      end
      ST_VERIFY:     if (verify_at) state_d = ST_IDLE;
      default:       state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    succeed = 1'b0;
    fail    = 1'b0;
    case (state_q)
      ST_MEASURE: begin
        if (last_fall)             fail = !div_ok;
        else if (cnt_q == CNT_MAX) fail = 1'b1;
      end
      ST_VERIFY: begin
        if (verify_at) begin
          succeed = line_level;
          fail    = !line_level;
        end
      end
      default: ;
    endcase
  end

  assign busy_o  = (state_q != ST_IDLE);
  assign debug_o = {state_q, edge_q, line_level, line_rise, line_fall};

  // Counters are shared: cnt_q times the measurement, then the wait to mid stop bit.
  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      cnt_q           <= '0;
      edge_q          <= '0;
      high_q          <= '0;
      div_q           <= '0;
      clock_divider_o <= DEFAULT_DIVIDER;
      locked_o        <= 1'b0;
      done_o          <= 1'b0;
      error_o         <= 1'b0;
    end else begin
      done_o  <= succeed;
      error_o <= fail;
      if (succeed) begin
        clock_divider_o <= div_q;
        locked_o        <= 1'b1;
      end
      case (state_q)
        ST_IDLE:      high_q <= '0;
        ST_WAIT_HIGH: high_q <= line_level ? high_q + 5'd1 : 5'd0;
        ST_WAIT_START: begin
          if (line_fall) begin
            cnt_q  <= '0;
            edge_q <= '0;
          end
        end
        ST_MEASURE: begin
          cnt_q <= cnt_q + 11'd1;
          if (line_fall) edge_q <= edge_q + 3'd1;
          if (last_fall) begin
            div_q <= meas_div[7:0];
            cnt_q <= '0;
          end
        end
        ST_VERIFY:    cnt_q <= cnt_q + 11'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_autobaud.sv
// Directed bench for uart_autobaud: frame-level outcome model, per-cycle output compare, fixed-value anchors.
module tb_uart_autobaud;
  import uart_autobaud_pkg::*;

  localparam logic [7:0] DEF_DIV = 8'd217;
  localparam int         MIN_DIV = 4;

  logic       clock_i  = 1'b0;
  logic       reset_i  = 1'b0;
  logic       start_i  = 1'b0;
  logic       serial_i = 1'b1;
  logic [7:0] clock_divider_o;
  logic       locked_o, busy_o, done_o, error_o;
  dbg_t       debug_o;

  uart_autobaud dut (
    .clock_i         (clock_i),
    .reset_i         (reset_i),
    .start_i         (start_i),
    .serial_i        (serial_i),
    .clock_divider_o (clock_divider_o),
    .locked_o        (locked_o),
    .busy_o          (busy_o),
    .done_o          (done_o),
    .error_o         (error_o),
    .debug_o         (debug_o)
  );

  // ---------------- clock / reset ----------------
  always #5 clock_i = ~clock_i;

  int cyc = 0;
  always @(posedge clock_i) cyc <= cyc + 1;

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [8:0] exp_q[$];   // {1=done/0=error, divider}
  logic [8:0] exp_e;
  logic [7:0] model_div;
  logic       model_locked;
  int         t_start = 0;
  int         last_evt_off = -1;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Outcome of one frame from the character, bit timing and stop level.
  function automatic logic [8:0] predict(input logic [7:0] data, input int bit_cycles,
                                         input int stretch_idx, input int stretch,
                                         input logic stop_val);
    int span, div;
    if (data != 8'h55) return 9'h000;
    span = 8 * bit_cycles + ((stretch_idx < 8) ? stretch : 0);
    div  = (span + 4) / 8;
    if (div < MIN_DIV || div > 255) return 9'h000;
    if (!stop_val) return 9'h000;
    return {1'b1, 8'(div)};
  endfunction

  always @(negedge clock_i) begin
    if (!reset_i) begin
      model_div    = DEF_DIV;
      model_locked = 1'b0;
      exp_q.delete();
      check("rst_divider", clock_divider_o, DEF_DIV);
      check("rst_locked", locked_o, 0);
      check("rst_busy", busy_o, 0);
      check("rst_done", done_o, 0);
      check("rst_error", error_o, 0);
    end else begin
      check("pulse_exclusive", done_o & error_o, 0);
      if (done_o || error_o) begin
        last_evt_off = cyc - t_start;
        check("busy_at_event", busy_o, 0);
        check("event_expected", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          exp_e = exp_q.pop_front();
          check("event_kind_done", done_o, exp_e[8]);
          if (exp_e[8]) begin
            model_div    = exp_e[7:0];
            model_locked = 1'b1;
          end
        end
      end
      check("divider", clock_divider_o, model_div);
      check("locked", locked_o, model_locked);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clock_i);
    #1;
  endtask

  task automatic pulse_start();
    start_i = 1'b1;
    tick(1);
    start_i = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] data, input int bit_cycles,
                            input int stretch_idx, input int stretch, input logic stop_val);
    logic [9:0] bits;
    bits    = {stop_val, data, 1'b0};
    t_start = cyc;
    for (int i = 0; i < 10; i++) begin
      serial_i = bits[i];
      tick(bit_cycles + ((i == stretch_idx) ? stretch : 0));
    end
    serial_i = 1'b1;
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 4000) begin
      tick(1);
      n++;
    end
    check({name, "_outcome_seen"}, int'(exp_q.size()), 0);
  endtask

  task automatic run_frame(input string name, input logic [7:0] data, input int bit_cycles,
                           input int stretch_idx, input int stretch, input logic stop_val);
    exp_q.push_back(predict(data, bit_cycles, stretch_idx, stretch, stop_val));
    pulse_start();
    check({name, "_busy_armed"}, busy_o, 1);
    tick(30);
    send_frame(data, bit_cycles, stretch_idx, stretch, stop_val);
    wait_idle(name);
    tick(40);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    tick(3);
    reset_i = 1'b1;
    tick(5);
    check("init_divider", clock_divider_o, 217);
    check("init_locked", locked_o, 0);

    run_frame("byte00", 8'h00, 217, 99, 0, 1'b1);
    check("timeout_offset", last_evt_off, 2051);
    check("byte00_divider", clock_divider_o, 217);
    check("byte00_locked", locked_o, 0);

    run_frame("div3", 8'h55, 3, 99, 0, 1'b1);
    check("div3_locked", locked_o, 0);

    run_frame("div217", 8'h55, 217, 99, 0, 1'b1);
    check("div217_divider", clock_divider_o, 217);
    check("div217_locked", locked_o, 1);

    run_frame("span1739", 8'h55, 217, 3, 3, 1'b1);
    check("span1739_divider", clock_divider_o, 217);

    run_frame("div16", 8'h55, 16, 99, 0, 1'b1);
    check("done_offset_16", last_evt_off, 155);
    check("div16_divider", clock_divider_o, 16);

    run_frame("div20", 8'h55, 20, 99, 0, 1'b1);
    check("div20_divider", clock_divider_o, 20);

    run_frame("stop_low", 8'h55, 20, 99, 0, 1'b0);
    check("stop_low_divider", clock_divider_o, 20);
    check("stop_low_locked", locked_o, 1);

    // Abort a measurement in progress with reset.
    pulse_start();
    tick(30);
    t_start  = cyc;
    serial_i = 1'b0;
    tick(60);
    check("abort_busy_measure", busy_o, 1);
    reset_i = 1'b0;
    tick(3);
    check("abort_divider", clock_divider_o, 217);
    check("abort_locked", locked_o, 0);
    check("abort_busy", busy_o, 0);
    serial_i = 1'b1;
    reset_i  = 1'b1;
    tick(40);

    run_frame("div50", 8'h55, 50, 99, 0, 1'b1);
    check("div50_divider", clock_divider_o, 50);
    check("div50_locked", locked_o, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
